// File: rtl/fixed_point_pkg.sv
// Shared signed fixed-point format (Q7.8) used by the MLP datapath and its sequencer.
package FixedPoint;

  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  typedef logic signed [WIDTH-1:0] sfp;

  localparam sfp ONE  = sfp'(1 << FRAC);
  localparam sfp HALF = sfp'(1 << (FRAC - 1));

endpackage

// File: rtl/mlp_train_sequencer_pkg.sv
// Common types for the MLP training sequencer and its scoring pipe.
package mlp_train_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRAIN,
    S_EVAL,
    S_TEST,
    S_DRAIN,
    S_FINISH
  } seq_state_t;

  typedef enum logic [1:0] {
    PH_TRAIN,
    PH_EVAL,
    PH_TEST
  } seq_phase_t;

  typedef struct packed {
    logic       valid;
    seq_phase_t phase;
  } score_tag_t;

endpackage

// File: rtl/mlp_score_pipe.sv
// Delays example tags and thresholded targets by LAT cycles so they meet the matching
// MLP prediction, then reports whether every output falls on the same side of HALF.
module mlp_score_pipe
  import FixedPoint::*;
  import mlp_train_sequencer_pkg::*;
#(
  parameter int LAT     = 1,
  parameter int OUTPUTS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       issue_valid,
  input  seq_phase_t issue_phase,
  input  sfp         expected   [OUTPUTS],
  input  sfp         prediction [OUTPUTS],
  output logic       score_valid,
  output seq_phase_t score_phase,
  output logic       score_hit
);

  score_tag_t               tag_q    [LAT];
  logic [OUTPUTS-1:0]       exp_bits [LAT];
  logic [OUTPUTS-1:0]       exp_now;

  always_comb begin
    exp_now = '0;
    for (int j = 0; j < OUTPUTS; j++) begin
      exp_now[j] = (expected[j] < HALF);
    end
  end

  // Stage 0 of exp_bits is the registered target; the remaining LAT-1 stages line it up
  // with the prediction, which arrives LAT cycles after the example index changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        tag_q[i]    <= '0;
        exp_bits[i] <= '0;
      end
    end else begin
      tag_q[0]    <= flush ? score_tag_t'('0) : score_tag_t'{valid: issue_valid, phase: issue_phase};
      exp_bits[0] <= exp_now;
      for (int i = 1; i < LAT; i++) begin
        tag_q[i]    <= flush ? score_tag_t'('0) : tag_q[i-1];
        exp_bits[i] <= exp_bits[i-1];
      end
    end
  end

  always_comb begin
    score_valid = tag_q[LAT-1].valid;
    score_phase = tag_q[LAT-1].phase;
    score_hit   = 1'b1;
    for (int j = 0; j < OUTPUTS; j++) begin
      if ((prediction[j] < HALF) != exp_bits[LAT-1][j]) score_hit = 1'b0;
    end
  end

endmodule

// File: rtl/mlp_train_sequencer.sv
// Drives an MLP through NUM_EPOCHS training passes and a scored test sweep.
// Define MLP_SEQ_TRAIN_EVAL_EN to add a scored EVAL pass over the training set after every epoch.
module mlp_train_sequencer
  import FixedPoint::*;
  import mlp_train_sequencer_pkg::*;
#(
  parameter int NUM_TRAIN  = 70,
  parameter int NUM_TEST   = 30,
  parameter int NUM_EPOCHS = 100,
  parameter int OUTPUTS    = 1,
  parameter int LAT        = 1,
  localparam int EX_W = $clog2(NUM_TRAIN + NUM_TEST),
  localparam int EP_W = $clog2(NUM_EPOCHS + 1),
  localparam int CO_W = $clog2(NUM_TEST + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  sfp              prediction [OUTPUTS],
  input  sfp              expected   [OUTPUTS],
  output logic [EX_W-1:0] example,
  output logic            training,
  output logic            busy,
  output logic [EP_W-1:0] epoch,
  output logic [CO_W-1:0] correct,
`ifdef MLP_SEQ_TRAIN_EVAL_EN
  output logic [$clog2(NUM_TRAIN+1)-1:0] train_correct,
`endif
  output logic            done
);

  localparam int DR_W = $clog2(LAT + 1);
  localparam logic [EX_W-1:0] LAST_TRAIN = EX_W'(NUM_TRAIN - 1);
  localparam logic [EX_W-1:0] FIRST_TEST = EX_W'(NUM_TRAIN);
  localparam logic [EX_W-1:0] LAST_TEST  = EX_W'(NUM_TRAIN + NUM_TEST - 1);

  seq_state_t      state, next_state;
  logic [EX_W-1:0] example_n;
  logic [EP_W-1:0] epoch_n;
  logic [CO_W-1:0] correct_n;
  logic [DR_W-1:0] drain_cnt, drain_n;
  logic            training_n, done_n;
  logic            issue_valid, score_valid, score_hit;
  seq_phase_t      issue_phase, score_phase;
`ifdef MLP_SEQ_TRAIN_EVAL_EN
  logic [$clog2(NUM_TRAIN+1)-1:0] train_correct_n;
`endif

  mlp_score_pipe #(.LAT(LAT), .OUTPUTS(OUTPUTS)) u_score (
    .clk         (clk),
    .rst         (rst),
    .flush       (abort),
    .issue_valid (issue_valid),
    .issue_phase (issue_phase),
    .expected    (expected),
    .prediction  (prediction),
    .score_valid (score_valid),
    .score_phase (score_phase),
    .score_hit   (score_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      example   <= '0;
      training  <= 1'b0;
      busy      <= 1'b0;
      epoch     <= '0;
      correct   <= '0;
      done      <= 1'b0;
      drain_cnt <= '0;
`ifdef MLP_SEQ_TRAIN_EVAL_EN
      train_correct <= '0;
`endif
    end else begin
      state     <= next_state;
      example   <= example_n;
      training  <= training_n;
      busy      <= (next_state != S_IDLE);
      epoch     <= epoch_n;
      correct   <= correct_n;
      done      <= done_n;
      drain_cnt <= drain_n;
`ifdef MLP_SEQ_TRAIN_EVAL_EN
      train_correct <= train_correct_n;
`endif
    end
  end

  // The tag for each issued example is taken from the registered state, so it enters
  // the score pipe on the same edge as the registered target.
  always_comb begin
    next_state  = state;
    example_n   = example;
    training_n  = 1'b0;
    epoch_n     = epoch;
    correct_n   = correct;
    done_n      = 1'b0;
    drain_n     = drain_cnt;
    issue_valid = 1'b0;
    issue_phase = PH_TRAIN;
`ifdef MLP_SEQ_TRAIN_EVAL_EN
    train_correct_n = train_correct;
`endif

    case (state)
      S_TRAIN: begin issue_valid = 1'b1; issue_phase = PH_TRAIN; end
      S_EVAL:  begin issue_valid = 1'b1; issue_phase = PH_EVAL;  end
      S_TEST:  begin issue_valid = 1'b1; issue_phase = PH_TEST;  end
      default: ;
    endcase

    if (score_valid && score_hit && score_phase == PH_TEST && correct < CO_W'(NUM_TEST))
      correct_n = correct + CO_W'(1);
`ifdef MLP_SEQ_TRAIN_EVAL_EN
    if (score_valid && score_hit && score_phase == PH_EVAL &&
        train_correct < ($clog2(NUM_TRAIN+1))'(NUM_TRAIN))
      train_correct_n = train_correct + ($clog2(NUM_TRAIN+1))'(1);
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_TRAIN;
          example_n  = '0;
          epoch_n    = '0;
          correct_n  = '0;
          training_n = 1'b1;
        end
      end
      S_TRAIN: begin
        if (example == LAST_TRAIN) begin
          epoch_n = epoch + EP_W'(1);
`ifdef MLP_SEQ_TRAIN_EVAL_EN
          next_state      = S_EVAL;
          example_n       = '0;
          train_correct_n = '0;
`else
          if (epoch_n < EP_W'(NUM_EPOCHS)) begin
            example_n  = '0;
            training_n = 1'b1;
          end else begin
            next_state = S_TEST;
            example_n  = FIRST_TEST;
          end
`endif
        end else begin
          example_n  = example + EX_W'(1);
          training_n = 1'b1;
        end
      end
`ifdef MLP_SEQ_TRAIN_EVAL_EN
      S_EVAL: begin
        if (example == LAST_TRAIN) begin
          next_state = S_DRAIN;
          drain_n    = DR_W'(LAT - 1);
        end else begin
          example_n = example + EX_W'(1);
        end
      end
`endif
      S_TEST: begin
        if (example == LAST_TEST) begin
          next_state = S_DRAIN;
          drain_n    = DR_W'(LAT - 1);
        end else begin
          example_n = example + EX_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt != '0) begin
          drain_n = drain_cnt - DR_W'(1);
        end else begin
`ifdef MLP_SEQ_TRAIN_EVAL_EN
          // A drain holding a training index can only follow an EVAL sweep.
          if (example == LAST_TRAIN) begin
            if (epoch < EP_W'(NUM_EPOCHS)) begin
              next_state = S_TRAIN;
              example_n  = '0;
              training_n = 1'b1;
            end else begin
              next_state = S_TEST;
              example_n  = FIRST_TEST;
            end
          end else begin
            next_state = S_FINISH;
            done_n     = 1'b1;
          end
`else
          next_state = S_FINISH;
          done_n     = 1'b1;
`endif
        end
      end
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase

    if (abort) begin
      next_state = S_IDLE;
      example_n  = example;
      training_n = 1'b0;
      done_n     = 1'b0;
      epoch_n    = epoch;
      correct_n  = correct;
`ifdef MLP_SEQ_TRAIN_EVAL_EN
      train_correct_n = train_correct;
`endif
    end
  end

endmodule

// File: doc/mlp_train_sequencer.md
# mlp_train_sequencer

Sequencer that drives an MLP through its epoch schedule and scores the test set. It sits between the example store and the MLP. It issues the example index and the `training` flag each cycle, repeats the training set for a configured number of epochs, then sweeps the test set. It also thresholds and scores predictions, aligning them with their examples across the MLP's latency. It replaces the testbench-side loop so that training and evaluation can run unattended in hardware.

## Interface
- `NUM_TRAIN`, 70: training examples, indices 0..NUM_TRAIN-1.
- `NUM_TEST`, 30: test examples, indices NUM_TRAIN..NUM_TRAIN+NUM_TEST-1.
- `NUM_EPOCHS`, 100: training passes; must be ≥1.
- `OUTPUTS`, 1: MLP output count.
- `LAT`, 1: cycles from `example` change to the matching `prediction`; must be ≥1.
- `clk` in 1: clock; all logic uses the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: begin schedule; sampled in IDLE only.
- `abort` in 1: synchronous abort; return to IDLE next cycle.
- `prediction[OUTPUTS]` in sfp: MLP output.
- `expected[OUTPUTS]` in sfp: example-store target for the current `example`.
- `example` out $clog2(NUM_TRAIN+NUM_TEST): example index.
- `training` out 1: MLP weight-update enable.
- `busy` out 1: high in any state except IDLE.
- `epoch` out $clog2(NUM_EPOCHS+1): completed training epochs.
- `correct` out $clog2(NUM_TEST+1): correctly classified test examples.
- `done` out 1: one-cycle pulse when `correct` is final.

## Operation
- States: IDLE, TRAIN, EVAL (only with macro), TEST, DRAIN, FINISH.
- IDLE → TRAIN when `start`=1:
  - `example`=0, `epoch`=0, `correct`=0 on entry.
- TRAIN:
  - `training`=1; `example` increments each cycle.
  - After index NUM_TRAIN-1, `epoch` increments.
  - Next state is EVAL (macro on), TRAIN with `example`=0 if `epoch`<NUM_EPOCHS, else TEST.
- TEST:
  - `training`=0; `example` runs NUM_TRAIN to NUM_TRAIN+NUM_TEST-1, then DRAIN.
- DRAIN: holds `example` at the last test index for LAT cycles, then FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- `correct` and `epoch` hold until the next `start`.
- Scoring:
  - A tag pipe of depth LAT carries (valid, phase) for each issued example.
  - A second pipe of depth LAT-1 carries the per-output bits `expected[j] < HALF`. `expected` is registered one cycle, so depth LAT-1 aligns it with `prediction`.
  - When a tag with phase=TEST emerges, the example counts as correct iff, for every j<OUTPUTS, (`prediction[j]` < HALF) == delayed expected bit. Comparison is signed sfp.
  - `correct` saturates at NUM_TEST.
- `abort`:
  - Any state → IDLE next cycle; `training`=0.
  - Tag pipe is flushed; `done` is not pulsed.
  - `epoch`/`correct` hold their partial values.
  - `abort` wins over `start` in the same cycle.
- Reset values:
  - state IDLE; `example`=0, `training`=0, `busy`=0, `epoch`=0, `correct`=0, `done`=0.
  - Pipes cleared.
  - Reset mid-run behaves identically to reset.

## Timing
- All outputs are registered.
- `start` at edge k: TRAIN at edge k+1, `example`=0, `training`=1.
- Epoch boundary: `example` wraps NUM_TRAIN-1 → 0 on the next edge with no idle cycle; `epoch` updates on that same edge.
- Last TRAIN cycle to first TEST cycle: consecutive; `training` falls on the edge where `example` becomes NUM_TRAIN.
- The prediction for the example issued at edge t is scored at edge t+LAT.
- `done` rises at edge (start edge)+NUM_EPOCHS·NUM_TRAIN+NUM_TEST+LAT+1. With the macro, the EVAL cycles are added.

## Configuration
- `MLP_SEQ_TRAIN_EVAL_EN` defined:
  - After each epoch, an EVAL pass sweeps indices 0..NUM_TRAIN-1 with `training`=0.
  - It is scored with phase=EVAL into an extra output `train_correct` ($clog2(NUM_TRAIN+1)). `train_correct` clears at EVAL entry.
  - The next epoch starts only after EVAL's drain of LAT cycles.
- Undefined: no EVAL state; `train_correct` port absent.

## Structure
- Common package holds:
  - `seq_state_t` enum (IDLE, TRAIN, EVAL, TEST, DRAIN, FINISH).
  - `seq_phase_t` enum (TRAIN, EVAL, TEST) for tags.
- `sfp` and `HALF` come from FixedPoint; no local copies.
- One sub-module, `mlp_score_pipe`:
  - Parameterised LAT/OUTPUTS shift register for tags and expected bits.
  - Flush input for `abort`; emits `score_valid`, `score_phase`, `score_hit`.

## Test plan
- NUM_TRAIN=4, NUM_TEST=3, NUM_EPOCHS=2, LAT=1, `start` pulse:
  - `example` reads 0,1,2,3,0,1,2,3,4,5,6 with `training`=1 for the first 8 cycles.
  - `epoch`=2, `done` pulses 1 cycle after DRAIN.
- Same config, `prediction` tied to 0.75 and `expected` 1.0,0.0,1.0 for the test examples → `correct`=2.
- LAT=3, `prediction` driven as `expected` delayed 3 cycles → `correct`=3. The same stimulus with 2-cycle delay → alignment mismatch, `correct`<3.
- `abort` asserted during TEST at `example`=5 → IDLE next cycle, `training`=0, `busy`=0, no `done`, `correct` holds.
- `rst` low during TRAIN → outputs reach reset values immediately (before the next edge); `start` after release → clean run, `epoch` restarts from 0.
- Macro on, NUM_EPOCHS=1, all predictions correct → `train_correct`=4 after EVAL, then `correct`=3 and `done` pulse; `done` timing shifts by NUM_TRAIN+LAT cycles.
